// File: rtl/dsp_pkg.sv
// Shared DSP datapath types and the saturating adder used by the overlap-add
// stage and the other fixed-point adders in the chain.
package dsp_pkg;

  localparam int SAMPLE_BITS = 12;

  typedef logic signed [SAMPLE_BITS-1:0] sample_t;

  typedef enum logic {IDLE, STREAM} ola_state_t;

  // Operands arrive sign-extended to 32 bits; w is the target width (2..31).
  // The add is done one bit wider so it cannot overflow before clamping.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned w);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = {a[31], a} + {b[31], b};
    hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo  = -(33'sd1 <<< (w - 1));
    if (sum > hi) begin
      sat_add = hi[31:0];
    end else if (sum < lo) begin
      sat_add = lo[31:0];
    end else begin
      sat_add = sum[31:0];
    end
  endfunction

endpackage

// File: rtl/overlap_add.sv
// Overlap-add synthesis: takes one windowed frame in parallel and streams HOP
// reconstructed samples, each the saturated sum of this frame and the prior tail.
module overlap_add
  import dsp_pkg::*;
#(
  parameter int SAMPLE_BITS = dsp_pkg::SAMPLE_BITS,
  parameter int WINDOW_SIZE = 128,
  parameter int HOP         = WINDOW_SIZE / 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic signed [SAMPLE_BITS-1:0] frame [0:WINDOW_SIZE-1],
  input  logic                          frame_valid,
  output logic                          frame_ready,
  output logic signed [SAMPLE_BITS-1:0] out,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int IDX_W = $clog2(HOP);

  if (HOP != WINDOW_SIZE / 2) begin : g_hop_check
    $error("overlap_add: HOP must equal WINDOW_SIZE/2");
  end

  ola_state_t                    state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic signed [SAMPLE_BITS-1:0] tail_q [0:HOP-1];
  logic signed [SAMPLE_BITS-1:0] obuf_q [0:HOP-1];
  logic signed [SAMPLE_BITS-1:0] sum_d  [0:HOP-1];

  logic last_beat;
  logic beat;
  logic accept;

  assign last_beat   = (idx_q == IDX_W'(HOP - 1));
  assign out_valid   = rst_n && (state_q == STREAM);
  assign beat        = out_valid && out_ready;
  // Ready only on the final beat of a stream, so a new frame lands with no bubble.
  assign frame_ready = rst_n && ((state_q == IDLE) || (last_beat && out_ready));
  assign accept      = frame_valid && frame_ready;
  // obuf_q and idx_q are both registers, so this mux is stable while stalled.
  assign out         = obuf_q[idx_q];

  always_comb begin
    for (int i = 0; i < HOP; i++) begin
      sum_d[i] = SAMPLE_BITS'(sat_add(32'(frame[i]), 32'(tail_q[i]), SAMPLE_BITS));
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (beat) begin
      idx_d = idx_q + 1'b1;
      if (last_beat) begin
        state_d = IDLE;
      end
    end
    if (accept) begin
      state_d = STREAM;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int i = 0; i < HOP; i++) begin
        tail_q[i] <= '0;
        obuf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) begin
        for (int i = 0; i < HOP; i++) begin
          obuf_q[i] <= sum_d[i];
          tail_q[i] <= frame[HOP+i];
        end
      end
    end
  end

endmodule

// File: tb/tb_overlap_add.sv
// Directed bench for overlap_add: table of two-frame overlap cases plus
// hand-written back-to-back, backpressure, mid-stream reset and idle-gap runs.
module tb_overlap_add;

  localparam int SB = 12;
  localparam int WS = 128;
  localparam int HP = 64;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic signed [SB-1:0] frame [0:WS-1];
  logic                 frame_valid = 1'b0;
  logic                 frame_ready;
  logic signed [SB-1:0] out;
  logic                 out_valid;
  logic                 out_ready = 1'b0;

  int errors = 0;
  int checks = 0;
  int expv [0:HP-1];

  typedef struct {
    int a_lo;
    int a_hi;
    int b_lo;
    int exp_a;
    int exp_b;
  } vec_t;

  vec_t vecs [0:6];

  always #5 clk = ~clk;

  overlap_add #(.SAMPLE_BITS(SB), .WINDOW_SIZE(WS), .HOP(HP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame      (frame),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .out        (out),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fill(input int lo, input int hi);
    for (int i = 0; i < HP; i++) begin
      frame[i]    = SB'(lo);
      frame[HP+i] = SB'(hi);
    end
  endtask

  task automatic set_exp(input int v);
    for (int i = 0; i < HP; i++) expv[i] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    frame_valid = 1'b0;
    out_ready   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Raises frame_valid and returns just before the accepting rising edge.
  task automatic send(input string name);
    int  n   = 0;
    bit  got = 1'b0;
    @(negedge clk);
    frame_valid = 1'b1;
    while (!got && n < 300) begin
      #1;
      if (frame_ready) got = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    if (!got) check({name, "_accept_timeout"}, 0, 1);
  endtask

  // Collects n beats against expv; bp applies the 1,0,0,1 out_ready pattern.
  task automatic collect(input string name, input int n, input bit bp);
    int b        = 0;
    int c        = 0;
    int held     = 0;
    bit hold_chk = 1'b0;
    while (b < n && c < n * 4 + 20) begin
      @(negedge clk);
      frame_valid = 1'b0;
      out_ready   = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      #1;
      if (c == 0) check({name, "_latency"}, int'(out_valid), 1);
      if (hold_chk) check({name, "_hold"}, out, held);
      hold_chk = 1'b0;
      if (out_valid && out_ready) begin
        check({name, "_data"}, out, expv[b]);
        check({name, "_fready"}, int'(frame_ready), int'(b == HP - 1));
        b++;
      end else if (out_valid) begin
        held     = out;
        hold_chk = 1'b1;
      end
      c++;
    end
    if (b < n) check({name, "_beats_timeout"}, b, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fill(0, 0);
    vecs[0] = '{a_lo: 100,   a_hi: 100,   b_lo: 100,   exp_a: 100,   exp_b: 200};
    vecs[1] = '{a_lo: 2000,  a_hi: 2000,  b_lo: 2000,  exp_a: 2000,  exp_b: 2047};
    vecs[2] = '{a_lo: -2000, a_hi: -2000, b_lo: -2000, exp_a: -2000, exp_b: -2048};
    vecs[3] = '{a_lo: 0,     a_hi: 7,     b_lo: 3,     exp_a: 0,     exp_b: 10};
    vecs[4] = '{a_lo: 2047,  a_hi: 2047,  b_lo: 2047,  exp_a: 2047,  exp_b: 2047};
    vecs[5] = '{a_lo: -2048, a_hi: -2048, b_lo: -2048, exp_a: -2048, exp_b: -2048};
    vecs[6] = '{a_lo: 5,     a_hi: -5,    b_lo: 5,     exp_a: 5,     exp_b: 0};

    // Reset state, sampled while rst_n is still low after a reset edge.
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_frame_ready", int'(frame_ready), 0);
    check("rst_out", out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_frame_ready", int'(frame_ready), 1);
    check("post_rst_out_valid", int'(out_valid), 0);

    // Two-frame overlap table: frame A against a zero tail, then B against A's tail.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      fill(vecs[v].a_lo, vecs[v].a_hi);
      send($sformatf("vec%0d_a", v));
      set_exp(vecs[v].exp_a);
      collect($sformatf("vec%0d_a", v), HP, 1'b0);
      fill(vecs[v].b_lo, 0);
      send($sformatf("vec%0d_b", v));
      set_exp(vecs[v].exp_b);
      collect($sformatf("vec%0d_b", v), HP, 1'b0);
      @(negedge clk);
      #1;
      check($sformatf("vec%0d_idle", v), int'(out_valid), 0);
    end

    // Back-to-back: three frames of ones, frame_valid held high.
    do_reset();
    fill(1, 1);
    send("b2b");
    for (int k = 0; k < 3 * HP; k++) begin
      @(negedge clk);
      if (k == 3 * HP - 1) frame_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      check("b2b_valid", int'(out_valid), 1);
      check("b2b_fready", int'(frame_ready), int'(k % HP == HP - 1));
      check("b2b_data", out, (k < HP) ? 1 : 2);
    end
    @(negedge clk);
    #1;
    check("b2b_end_valid", int'(out_valid), 0);

    // Backpressure with a ramp frame.
    do_reset();
    for (int i = 0; i < HP; i++) begin
      frame[i]    = SB'(i);
      frame[HP+i] = '0;
      expv[i]     = i;
    end
    send("bp");
    collect("bp", HP, 1'b1);

    // Reset in the middle of a stream at idx 30.
    do_reset();
    fill(100, 500);
    send("mrst");
    set_exp(100);
    collect("mrst_pre", 30, 1'b0);
    @(negedge clk);
    rst_n     = 1'b0;
    out_ready = 1'b1;
    #1;
    check("mrst_valid_in_rst", int'(out_valid), 0);
    check("mrst_fready_in_rst", int'(frame_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mrst_fready_after", int'(frame_ready), 1);
    check("mrst_valid_after", int'(out_valid), 0);
    check("mrst_out_after", out, 0);
    fill(50, 50);
    send("mrst_50");
    set_exp(50);
    collect("mrst_50", HP, 1'b0);

    // Idle gap: tail of frame A survives 20 idle cycles.
    do_reset();
    fill(0, 7);
    send("gap_a");
    set_exp(0);
    collect("gap_a", HP, 1'b0);
    repeat (20) @(negedge clk);
    #1;
    check("gap_idle_valid", int'(out_valid), 0);
    check("gap_idle_fready", int'(frame_ready), 1);
    fill(3, 0);
    send("gap_b");
    set_exp(10);
    collect("gap_b", HP, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/overlap_add.md
# overlap_add

Streaming overlap-add synthesis block: accepts parallel windowed frames of WINDOW_SIZE samples, one per handshake, and emits a continuous serial sample stream with 50 % overlap (hop = WINDOW_SIZE/2). It is the frame-to-stream counterpart of the analysis windowing stage. It sits at the output of the frame-processing chain and reconstructs the time-domain stream for the DAC/output path.

## Interface
- SAMPLE_BITS, 12, width of each signed two's-complement sample
- WINDOW_SIZE, 128, samples per frame; power of two, ≥4
- HOP, WINDOW_SIZE/2, samples emitted per frame; must equal WINDOW_SIZE/2 (elaboration-time assertion)

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- frame  in  SAMPLE_BITS × [0:WINDOW_SIZE-1]  unpacked array of signed windowed samples
- frame_valid  in  1  frame holds a new frame
- frame_ready  out  1  block can accept a frame this cycle
- out  out  SAMPLE_BITS  signed reconstructed sample
- out_valid  out  1  out holds a valid sample
- out_ready  in  1  downstream accepts out this cycle

## Operation
- Internal state: tail[0:HOP-1] (second half of previous frame), obuf[0:HOP-1] (samples being streamed), idx (log2(HOP) bits), FSM {IDLE, STREAM}.
- Frame accept = frame_valid && frame_ready. On accept: obuf[i] <= sat(frame[i] + tail[i]), tail[i] <= frame[HOP+i] for i in 0..HOP-1; idx <= 0; state <= STREAM.
- Addition is full-precision (SAMPLE_BITS+1), then saturated to [-2^(SAMPLE_BITS-1), 2^(SAMPLE_BITS-1)-1].
- IDLE: frame_ready = 1, out_valid = 0.
- STREAM: out_valid = 1, out = obuf[idx]. Beat = out_valid && out_ready; on beat idx increments. If out_ready is low, out and idx hold.
- frame_ready in STREAM = 1 only when idx == HOP-1 and out_ready = 1 (last beat). Accept on last beat reloads obuf, idx <= 0, state stays STREAM: zero-bubble back-to-back frames.
- Last beat without accept: state <= IDLE; idx wraps to 0.
- tail persists across IDLE gaps; the first frame after reset overlaps with zeros.
- frame_valid when frame_ready = 0 is ignored (no accept); the source holds frame until accepted.

## Timing
- Reset (rst_n low at a rising edge): state = IDLE, idx = 0, tail = 0, obuf = 0, out = 0, out_valid = 0. frame_ready = 0 while rst_n is low; it is 1 from the first cycle after rst_n goes high.
- Latency: accept at edge T gives out_valid = 1 with obuf[0] in cycle T+1.
- Throughput: with out_ready held high, one frame per HOP cycles, with no idle cycle between frames.
- Reset mid-stream: it discards obuf and tail immediately. out_valid is 0 in the next cycle. No partial frame is resumed.
- out is a registered output, driven from obuf[idx] through a flop or a stable mux. It must not glitch while out_ready = 0.

## Structure
- Shared package dsp_pkg holds:
  - sample_t typedef (logic signed [SAMPLE_BITS-1:0])
  - sat_add function (signed add with saturation)
  - ola_state_t enum {IDLE, STREAM}
- The saturation function is shared with the other DSP adders.
- No sub-module. tail and obuf are plain register arrays, because the frame is accepted in parallel. ROM or RAM inference does not apply.

## Test plan
- Reset then single frame, all samples 100, out_ready = 1. Required: first frame yields 64 beats of 100. Second identical frame yields 64 beats of 200 (overlap with tail), starting at cycle T+1 after accept.
- Saturation, SAMPLE_BITS = 12:
  - tail = 2000 and frame[i] = 2000 → 2047.
  - tail = -2000 and frame[i] = -2000 → -2048.
- Back-to-back frames, frame_valid held high, out_ready = 1. Required: frame_ready pulses only on idx = 63. out_valid stays 1 continuously across 3 frames (192 beats, no gap).
- Backpressure: out_ready toggles 1,0,0,1 pattern. Required: out holds its value while out_ready = 0. No sample is dropped or duplicated, checked as a ramp frame[i] = i giving output 0..63 in order.
- Reset mid-stream: assert rst_n = 0 at idx = 30 for one cycle. Required: out_valid = 0 and frame_ready = 0 in the reset cycle, and frame_ready = 1 the cycle after. The next frame of 50s outputs 50 (tail cleared), not 50 + old tail.
- Idle gap: after frame A (second half = 7), wait 20 idle cycles, then send frame B (first half = 3). Required: output = 10 for all 64 beats (tail persisted through IDLE).
